// File: rtl/decoder_pkg.sv
// Shared types and decode helper for the pipelined one-hot/thermometer decoder.
// The helper builds a maximum-width vector; callers keep the low NUM_OUTPUTS bits.
package decoder_pkg;

  localparam int unsigned DEC_MAX_OUTPUTS = 256;

  typedef enum logic {
    DEC_ONEHOT = 1'b0,
    DEC_THERMO = 1'b1
  } dec_mode_e;

  // Encoded as {main_v, skid_v}
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  typedef struct packed {
    logic                       out_of_range;
    logic [DEC_MAX_OUTPUTS-1:0] vec;
  } dec_result_t;

  function automatic dec_result_t dec_decode(input logic [31:0] idx,
                                             input logic [31:0] num_outputs,
                                             input dec_mode_e   mode);
    dec_result_t res;
    res.vec          = '0;
    res.out_of_range = (idx >= num_outputs);
    if (!res.out_of_range) begin
      for (int unsigned i = 0; i < DEC_MAX_OUTPUTS; i++) begin
        if (mode == DEC_THERMO) res.vec[i] = (i <= idx);
        else                    res.vec[i] = (i == idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational binary -> one-hot/thermometer decode with range detection.
module decode_comb
  import decoder_pkg::*;
#(
  parameter int unsigned BINARY_BITS = 3,
  parameter int unsigned NUM_OUTPUTS = 2 ** BINARY_BITS,
  parameter bit          THERMO_EN   = 1'b1
) (
  input  logic [BINARY_BITS-1:0] binary,
  input  logic                   mode,
  output logic [NUM_OUTPUTS-1:0] vec,
  output logic                   out_of_range
);

  dec_mode_e   eff_mode;
  dec_result_t res;
  logic        unused_res;

  assign eff_mode     = (THERMO_EN && mode) ? DEC_THERMO : DEC_ONEHOT;
  assign res          = dec_decode(32'(binary), 32'(NUM_OUTPUTS), eff_mode);
  assign vec          = res.vec[NUM_OUTPUTS-1:0];
  assign out_of_range = res.out_of_range;
  // Bits above NUM_OUTPUTS are always zero from the helper
  assign unused_res   = ^res.vec;

endmodule

// File: rtl/decoder_pipe.sv
// Registered decoder with valid/ready on both sides and a 2-entry skid buffer,
// so in_ready is a flop and never a combinational function of out_ready.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int unsigned BINARY_BITS = 3,
  parameter int unsigned NUM_OUTPUTS = 2 ** BINARY_BITS,
  parameter bit          THERMO_EN   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BINARY_BITS-1:0] binary,
  input  logic                   mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_OUTPUTS-1:0] onehot,
  output logic                   out_of_range
);

  logic [NUM_OUTPUTS-1:0] dec_vec;
  logic                   dec_oor;

  skid_state_e            state_q, state_d;
  logic [NUM_OUTPUTS-1:0] main_vec_q, main_vec_d;
  logic                   main_oor_q, main_oor_d;
  logic [NUM_OUTPUTS-1:0] skid_vec_q, skid_vec_d;
  logic                   skid_oor_q, skid_oor_d;
  logic                   in_ready_q, in_ready_d;
  logic                   in_xfer, out_xfer;

  decode_comb #(
    .BINARY_BITS (BINARY_BITS),
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .THERMO_EN   (THERMO_EN)
  ) u_decode (
    .binary       (binary),
    .mode         (mode),
    .vec          (dec_vec),
    .out_of_range (dec_oor)
  );

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = state_q[1] & out_ready;

  always_comb begin
    state_d    = state_q;
    main_vec_d = main_vec_q;
    main_oor_d = main_oor_q;
    skid_vec_d = skid_vec_q;
    skid_oor_d = skid_oor_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          state_d    = SKID_ONE;
          main_vec_d = dec_vec;
          main_oor_d = dec_oor;
        end
      end
      SKID_ONE: begin
        if (in_xfer && out_xfer) begin
          main_vec_d = dec_vec;
          main_oor_d = dec_oor;
        end else if (in_xfer) begin
          state_d    = SKID_FULL;
          skid_vec_d = dec_vec;
          skid_oor_d = dec_oor;
        end else if (out_xfer) begin
          // Clear the outputs so an idle pipe presents zero
          state_d    = SKID_EMPTY;
          main_vec_d = '0;
          main_oor_d = 1'b0;
        end
      end
      SKID_FULL: begin
        if (out_xfer) begin
          state_d    = SKID_ONE;
          main_vec_d = skid_vec_q;
          main_oor_d = skid_oor_q;
        end
      end
      default: begin
        state_d    = SKID_EMPTY;
        main_vec_d = '0;
        main_oor_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= SKID_EMPTY;
      main_vec_q <= '0;
      main_oor_q <= 1'b0;
      skid_vec_q <= '0;
      skid_oor_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_vec_q <= main_vec_d;
      main_oor_q <= main_oor_d;
      skid_vec_q <= skid_vec_d;
      skid_oor_q <= skid_oor_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = state_q[1];
  assign onehot       = main_vec_q;
  assign out_of_range = main_oor_q;

endmodule
